// File: rtl/aes_key_sched_ctrl_if.sv
// Round-key delivery channel between the key-schedule sequencer and the cipher datapath.
interface aes_key_sched_ctrl_if;
  logic [127:0] round_key;
  logic [3:0]   rk_index;
  logic         rk_valid;
  logic         rk_ready;

  modport master (output round_key, output rk_index, output rk_valid, input rk_ready);
  modport slave  (input round_key, input rk_index, input rk_valid, output rk_ready);
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key expansion: one round key per EMIT/CALC pair, handed out over valid/ready.
// SubWord is supplied by an external combinational S-box bank through sb_in/sb_out.
module aes_key_sched_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [127:0]                key_in,
  output logic [31:0]                 sb_in,
  input  logic [31:0]                 sb_out,
  aes_key_sched_ctrl_if.master        rk,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    CALC = 2'd2
  } state_t;

  localparam logic [3:0] NR_IDX = 4'(NR);

  state_t       state_r, state_s;
  logic [127:0] key_r, key_s;
  logic [127:0] round_key_r, round_key_s;
  logic [3:0]   round_r, round_s;
  logic [3:0]   rk_index_r, rk_index_s;
  logic         rk_valid_r, rk_valid_s;
  logic         busy_r, busy_s;
  logic         done_r, done_s;
  logic [3:0]   round_inc_s;
  logic [31:0]  t_s, n0_s, n1_s, n2_s, n3_s;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // RotWord(w3) feeds the external S-box; only consumed while in CALC
  assign sb_in       = {key_r[23:0], key_r[31:24]};
  assign round_inc_s = round_r + 4'd1;
  assign t_s         = sb_out ^ {rcon(round_inc_s), 24'h000000};
  assign n0_s        = key_r[127:96] ^ t_s;
  assign n1_s        = key_r[95:64]  ^ n0_s;
  assign n2_s        = key_r[63:32]  ^ n1_s;
  assign n3_s        = key_r[31:0]   ^ n2_s;

  assign rk.round_key = round_key_r;
  assign rk.rk_index  = rk_index_r;
  assign rk.rk_valid  = rk_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;

  // Next-state and next-output decode
  always_comb begin
    state_s     = state_r;
    key_s       = key_r;
    round_s     = round_r;
    round_key_s = round_key_r;
    rk_index_s  = rk_index_r;
    rk_valid_s  = rk_valid_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s     = EMIT;
          key_s       = key_in;
          round_s     = 4'd0;
          round_key_s = key_in;
          rk_index_s  = 4'd0;
          rk_valid_s  = 1'b1;
          busy_s      = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (rk.rk_ready) begin
          rk_valid_s = 1'b0;
          if (round_r == NR_IDX) begin
            state_s = IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = EMIT;
        end
      end
      CALC: begin
        state_s     = EMIT;
        key_s       = {n0_s, n1_s, n2_s, n3_s};
        round_s     = round_inc_s;
        round_key_s = {n0_s, n1_s, n2_s, n3_s};
        rk_index_s  = round_inc_s;
        rk_valid_s  = 1'b1;
      end
      default: begin
        state_s    = IDLE;
        rk_valid_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial expansion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      key_r       <= 128'h0;
      round_r     <= 4'd0;
      round_key_r <= 128'h0;
      rk_index_r  <= 4'd0;
      rk_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      key_r       <= key_s;
      round_r     <= round_s;
      round_key_r <= round_key_s;
      rk_index_r  <= rk_index_s;
      rk_valid_r  <= rk_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench: an NR=10 and an NR=1 sequencer against a word-level FIPS-197 expansion model.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_FIPS1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_FIPSA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_SEQA  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start;
  logic [127:0] key_in;
  logic [31:0]  sb_in0, sb_out0, sb_in1, sb_out1;
  logic         busy0, done0, busy1, done1;

  aes_key_sched_ctrl_if rk0();
  aes_key_sched_ctrl_if rk1();

  aes_key_sched_ctrl #(.NR(10)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .sb_in(sb_in0), .sb_out(sb_out0), .rk(rk0), .busy(busy0), .done(done0)
  );
  aes_key_sched_ctrl #(.NR(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .sb_in(sb_in1), .sb_out(sb_out1), .rk(rk1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r = 8'h01;
    logic [7:0] s = b;
    logic [7:0] v;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    v = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return v;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  assign sb_out0 = sub_word(sb_in0);
  assign sb_out1 = sub_word(sb_in1);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model state, one slot per instance
  int           nr_of[2] = '{10, 1};
  bit           m_live[2], m_active[2], m_valid[2], m_done[2], m_zero[2];
  int           m_next[2];
  int           xfer_cnt[2];
  logic [127:0] mk[2][11];
  logic [127:0] cap[2][11];

  task automatic expand(input int u, input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word(rot_word(tmp)) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mk[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_cycle(input int u, input logic busy_a, input logic done_a,
                             input logic valid_a, input logic [3:0] idx_a,
                             input logic [127:0] key_a, input logic [31:0] sbi_a,
                             input logic ready);
    string p = (u == 0) ? "nr10" : "nr1";
    if (m_live[u]) begin
      chk({p, ".busy"}, 128'(busy_a), 128'(m_active[u]));
      chk({p, ".valid"}, 128'(valid_a), 128'(m_valid[u]));
      chk({p, ".done"}, 128'(done_a), 128'(m_done[u]));
      if (m_valid[u]) begin
        chk({p, ".rk_index"}, 128'(idx_a), 128'(m_next[u]));
        chk({p, ".round_key"}, key_a, mk[u][m_next[u]]);
      end else if (m_active[u]) begin
        chk({p, ".sb_in"}, 128'(sbi_a), 128'(rot_word(mk[u][m_next[u]-1][31:0])));
      end
      if (m_zero[u]) begin
        chk({p, ".rst_key"}, key_a, 128'h0);
        chk({p, ".rst_idx"}, 128'(idx_a), 128'h0);
      end
    end
    m_done[u] = 1'b0;
    m_zero[u] = 1'b0;
    if (rst) begin
      m_live[u]   = 1'b1;
      m_active[u] = 1'b0;
      m_valid[u]  = 1'b0;
      m_next[u]   = 0;
      m_zero[u]   = 1'b1;
    end else if (!m_active[u]) begin
      if (start) begin
        expand(u, key_in);
        m_active[u] = 1'b1;
        m_valid[u]  = 1'b1;
        m_next[u]   = 0;
        xfer_cnt[u] = 0;
      end
    end else if (m_valid[u] && ready) begin
      cap[u][m_next[u]] = key_a;
      xfer_cnt[u]++;
      m_valid[u] = 1'b0;
      if (m_next[u] == nr_of[u]) begin
        m_active[u] = 1'b0;
        m_done[u]   = 1'b1;
      end else begin
        m_next[u]++;
      end
    end else if (!m_valid[u]) begin
      m_valid[u] = 1'b1;
    end
  endtask

  // Compare-then-predict on the falling edge, when inputs for the next rising edge are settled
  always @(negedge clk) begin
    model_cycle(0, busy0, done0, rk0.rk_valid, rk0.rk_index, rk0.round_key, sb_in0, rk0.rk_ready);
    model_cycle(1, busy1, done1, rk1.rk_valid, rk1.rk_index, rk1.round_key, sb_in1, rk1.rk_ready);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input bit rnd);
    rk0.rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    rk1.rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Start a run in the current cycle and stop in the cycle where dut0 pulses done
  task automatic run(input string name, input logic [127:0] k, input bit rnd,
                     input int stray, input int exp_cyc);
    int cyc = 0;
    key_in = k;
    start  = 1'b1;
    set_ready(rnd);
    do begin
      step();
      cyc++;
      start = (cyc == stray);
      set_ready(rnd);
    end while (cyc < 600 && done0 !== 1'b1);
    start = 1'b0;
    chk({name, ".done_seen"}, 128'(done0), 128'h1);
    if (exp_cyc >= 0) chk({name, ".done_cycle"}, 128'(cyc), 128'(exp_cyc));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    key_in = 128'h0;
    rk0.rk_ready = 1'b0;
    rk1.rk_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset.busy", 128'(busy0), 128'h0);
    chk("reset.valid", 128'(rk0.rk_valid), 128'h0);
    chk("reset.done", 128'(done0), 128'h0);
    chk("reset.key", rk0.round_key, 128'h0);

    run("fips", K_FIPS, 1'b0, -1, 22);
    chk("fips.model_idx1", mk[0][1], K_FIPS1);
    chk("fips.idx0", cap[0][0], K_FIPS);
    chk("fips.idx1", cap[0][1], K_FIPS1);
    chk("fips.idx10", cap[0][10], K_FIPSA);
    chk("fips.count", 128'(xfer_cnt[0]), 128'd11);
    chk("nr1.idx1", cap[1][1], K_FIPS1);
    chk("nr1.count", 128'(xfer_cnt[1]), 128'd2);
    step();

    run("bp", K_FIPS, 1'b1, -1, -1);
    chk("bp.idx10", cap[0][10], K_FIPSA);
    chk("bp.count", 128'(xfer_cnt[0]), 128'd11);
    step();

    run("stray", K_FIPS, 1'b0, 5, 22);
    chk("stray.idx10", cap[0][10], K_FIPSA);
    repeat (2) step();

    key_in = K_FIPS;
    start = 1'b1;
    set_ready(1'b0);
    step();
    start = 1'b0;
    repeat (7) step();
    chk("calc4.busy", 128'(busy0), 128'h1);
    chk("calc4.valid", 128'(rk0.rk_valid), 128'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst4.busy", 128'(busy0), 128'h0);
    chk("rst4.valid", 128'(rk0.rk_valid), 128'h0);
    chk("rst4.idx", 128'(rk0.rk_index), 128'h0);
    chk("rst4.key", rk0.round_key, 128'h0);
    step();
    run("restart", K_FIPS, 1'b0, -1, 22);
    chk("restart.idx0", cap[0][0], K_FIPS);
    run("done_start", K_SEQ, 1'b0, -1, 22);
    chk("done_start.model_idx10", mk[0][10], K_SEQA);
    chk("done_start.idx10", cap[0][10], K_SEQA);
    step();

    for (int n = 0; n < 6; n++) begin
      run("rand", {$urandom, $urandom, $urandom, $urandom}, 1'b1,
          int'($urandom_range(2, 30)), -1);
      chk("rand.count", 128'(xfer_cnt[0]), 128'd11);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
